// File: rtl/csa_pipe_adder_if.sv
// Operand/result bundle for csa_pipe_adder: input beat handshake plus result handshake.
interface csa_pipe_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake and whole-pipe stall.
// Each stage resolves STG_BLKS blocks of BLK bits using the carry registered by the previous stage.
module csa_pipe_adder #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned BLK      = 4,
   parameter int unsigned STG_BLKS = 2
) (
   input logic             clk,
   input logic             rst,
   csa_pipe_adder_if.slave bus
);
   localparam int unsigned NB  = WIDTH / BLK;
   localparam int unsigned NS  = (NB + STG_BLKS - 1) / STG_BLKS;
   localparam int unsigned MSB = WIDTH - 1;

   // Stage k inputs: index 0 is the incoming beat, index k>0 is stage k-1's register.
   logic             v_in  [NS];
   logic             c_in  [NS];
   logic [WIDTH-1:0] r_in  [NS];
   logic [WIDTH-1:0] a_in  [NS];
   logic [WIDTH-1:0] bb_in [NS];

   logic             v_d   [NS];
   logic             v_q   [NS];
   logic             c_d   [NS];
   logic             c_q   [NS];
   logic [WIDTH-1:0] r_d   [NS];
   logic [WIDTH-1:0] r_q   [NS];
   logic [WIDTH-1:0] a_d   [NS];
   logic [WIDTH-1:0] a_q   [NS];
   logic [WIDTH-1:0] bb_d  [NS];
   logic [WIDTH-1:0] bb_q  [NS];
   logic             ovf_d;
   logic             ovf_q;
   logic             stall;

   always_comb begin
      v_in[0]  = bus.in_valid;
      c_in[0]  = bus.sub ? ~bus.cin : bus.cin;
      r_in[0]  = '0;
      a_in[0]  = bus.a;
      bb_in[0] = bus.sub ? ~bus.b : bus.b;
      for (int unsigned k = 1; k < NS; k++) begin
         v_in[k]  = v_q[k-1];
         c_in[k]  = c_q[k-1];
         r_in[k]  = r_q[k-1];
         a_in[k]  = a_q[k-1];
         bb_in[k] = bb_q[k-1];
      end
   end

   always_comb begin
      logic         cy;
      logic [BLK:0] s0;
      logic [BLK:0] s1;
      cy = 1'b0;
      s0 = '0;
      s1 = '0;
      for (int unsigned k = 0; k < NS; k++) begin
         cy     = c_in[k];
         r_d[k] = r_in[k];
         // A trailing stage with fewer than STG_BLKS blocks simply skips the missing ones.
         for (int unsigned j = 0; j < STG_BLKS; j++) begin
            if (k * STG_BLKS + j < NB) begin
               s0 = {1'b0, a_in[k][(k*STG_BLKS+j)*BLK +: BLK]}
                  + {1'b0, bb_in[k][(k*STG_BLKS+j)*BLK +: BLK]};
               s1 = {1'b0, a_in[k][(k*STG_BLKS+j)*BLK +: BLK]}
                  + {1'b0, bb_in[k][(k*STG_BLKS+j)*BLK +: BLK]} + (BLK+1)'(1);
               {cy, r_d[k][(k*STG_BLKS+j)*BLK +: BLK]} = cy ? s1 : s0;
            end
         end
         c_d[k]  = cy;
         v_d[k]  = v_in[k];
         a_d[k]  = a_in[k];
         bb_d[k] = bb_in[k];
      end
      ovf_d = (a_in[NS-1][MSB] == bb_in[NS-1][MSB]) && (r_d[NS-1][MSB] != a_in[NS-1][MSB]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < NS; k++) begin
            v_q[k]  <= 1'b0;
            c_q[k]  <= 1'b0;
            r_q[k]  <= '0;
            a_q[k]  <= '0;
            bb_q[k] <= '0;
         end
         ovf_q <= 1'b0;
      end else if (!stall) begin
         for (int unsigned k = 0; k < NS; k++) begin
            v_q[k]  <= v_d[k];
            c_q[k]  <= c_d[k];
            r_q[k]  <= r_d[k];
            a_q[k]  <= a_d[k];
            bb_q[k] <= bb_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

   always_comb begin
      stall         = v_q[NS-1] && !bus.out_ready;
      bus.in_ready  = !stall;
      bus.out_valid = v_q[NS-1];
      bus.sum       = r_q[NS-1];
      bus.cout      = c_q[NS-1];
      bus.ovf       = ovf_q;
   end
endmodule

// File: doc/csa_pipe_adder.md
Name: csa_pipe_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor; successor to the fixed-width combinational carry-select adders.
- Operand width is split into BLK-bit carry-select blocks. Pipeline registers are inserted every STG_BLKS blocks.
- A valid/ready handshake with full-pipeline stall is provided, so the block drops into datapaths that use backpressure.
- Adds a subtract mode, carry/borrow out and signed-overflow flag.

Parameters:
- WIDTH, 16: operand/sum width; must be a multiple of BLK.
- BLK, 4: carry-select block width. NB = WIDTH/BLK blocks.
- STG_BLKS, 2: blocks per pipeline stage. Latency L = ceil(NB/STG_BLKS) cycles; must be ≥1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in (add) / borrow in (sub)
- sub  in  1  0: A+B+cin; 1: A−B−cin
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out (add) / NOT borrow (sub), i.e. raw adder carry
- ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset (async, rst=1): all stage valid bits=0, out_valid=0, sum=0, cout=0, ovf=0. Data regs clear to 0. in_ready=1 one combinational path after reset releases.
- Operation: bb = sub ? ~b : b; c0 = sub ? ~cin : cin. Result is {cout,sum} = a + bb + c0, computed mod 2^(WIDTH+1).
- ovf = (a[MSB] == bb[MSB]) && (sum[MSB] != a[MSB]).
- Each block computes sum0/carry0 (assumed cin 0) and sum1/carry1 (assumed cin 1) in parallel. It muxes on the incoming block carry. Ripple within a block is allowed.
- Stage k resolves blocks k*STG_BLKS .. (k+1)*STG_BLKS−1 using the carry registered from stage k−1. Stage 0 uses c0.
- Per stage: a valid bit, the carry, the already-resolved low sum bits, and the not-yet-processed upper operand bits (bb pre-inverted) and ovf sign bits.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - When stall=1, every stage register holds its contents.
  - Otherwise all stages advance by one and stage 0 loads the input beat. Its valid bit = in_valid.
  - Bubbles propagate: invalid stages advance without affecting valid beats.
- Latency: a beat accepted in cycle n appears with out_valid=1 in cycle n+L if there is no stall. Throughput is one beat/cycle with out_ready held high.
- Output stability: while out_valid && !out_ready, sum/cout/ovf are held unchanged.
- Data/operand changes while in_ready=0 are ignored.
- Edge cases:
  - NB not a multiple of STG_BLKS: the last stage contains the remaining blocks.
  - STG_BLKS ≥ NB gives L=1 (single registered adder).
  - Full wrap: 0xFFFF+0x0001 → sum 0x0000, cout 1.
- Reset mid-operation: all in-flight beats are discarded immediately. No partial result is ever presented.
- No X propagation: the data path is driven from registers only; out_valid gates nothing internally.

Test Plan (WIDTH=16, BLK=4, STG_BLKS=2, L=2):
1. Reset, then idle with in_valid=0 → out_valid=0, sum=0x0000, cout=0, ovf=0, in_ready=1 for all cycles.
2. Add wrap/carry chain:
   - a=0xFFFF, b=0x0001, cin=0, sub=0 accepted cycle n → cycle n+2: sum=0x0000, cout=1, ovf=0.
   - a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
3. Subtract with borrow:
   - a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0, ovf=0.
   - a=0x8000, b=0x0001, sub=1, cin=1 → sum=0x7FFE, cout=1, ovf=1.
4. Streaming: back-to-back beats (1+2, 3+4, 0x00FF+0x0F01) with out_ready=1 → results 0x0003, 0x0007, 0x1000 on three consecutive cycles starting n+2.
5. Backpressure:
   - Stream 4 beats and hold out_ready=0 for 3 cycles once out_valid rises → in_ready=0 during the stall, output held constant.
   - Release → remaining beats emerge in order with no loss or duplication.
6. Async reset pulse asserted mid-stream (between clock edges, 2 beats in flight) → out_valid=0 and sum=0 immediately. No result from the flushed beats appears after reset deasserts.
7. Random regression: 10k random a/b/cin/sub with random in_valid/out_ready against a reference model. Also run with WIDTH=10, BLK=2, STG_BLKS=3 (NB=5, L=2).
